// File: rtl/utim64_pkg.sv
// Shared definitions for the utim64 compare/interrupt blocks: channel count,
// arbiter state encoding and a 64-bit zero constant.
package utim64_pkg;

  localparam int CH_N_DEFAULT = 4;

  localparam logic [63:0] ZERO64 = 64'd0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/compare_channel.sv
// One compare channel: config registers, match against the main counter,
// periodic reload, and the pending/overrun flags seen by the arbiter.
module compare_channel
  import utim64_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] counter,
  input  logic        working,
  input  logic        write,
  input  logic        cfg_ena,
  input  logic        cfg_periodic,
  input  logic [63:0] cfg_compare,
  input  logic [63:0] cfg_period,
  input  logic        clear_pending,
  output logic        pending,
  output logic        overrun
);

  logic        ena;
  logic        periodic;
  logic [63:0] compare;
  logic [63:0] period;
  logic        match;

  assign match = working && ena && (counter == compare);

  always_ff @(posedge clk) begin
    if (reset) begin
      ena      <= 1'b0;
      periodic <= 1'b0;
      compare  <= ZERO64;
      period   <= ZERO64;
      pending  <= 1'b0;
      overrun  <= 1'b0;
    end else if (write) begin
      // A config write discards any match on this channel in the same cycle.
      ena      <= cfg_ena;
      periodic <= cfg_periodic;
      compare  <= cfg_compare;
      period   <= cfg_period;
      overrun  <= 1'b0;
      if (clear_pending) pending <= 1'b0;
    end else begin
      if (match) begin
        // The arbiter's clear beats a coincident re-match and raises no overrun.
        if (clear_pending)   pending <= 1'b0;
        else if (pending)    overrun <= 1'b1;
        else                 pending <= 1'b1;
        if (periodic && (period != ZERO64)) compare <= compare + period;
        else                                ena     <= 1'b0;
      end else if (clear_pending) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/compare_irq_scheduler.sv
// Compare-match scheduler: CH_N compare channels whose pending matches are
// serialised onto one valid/ack interrupt port by a round-robin arbiter.
module compare_irq_scheduler
  import utim64_pkg::*;
#(
  parameter int CH_N = CH_N_DEFAULT,
  parameter int CH_W = $clog2(CH_N)
) (
  input  logic            iCLOCK,
  input  logic            iRESET_SYNC,
  input  logic [63:0]     iCOUNTER,
  input  logic            iWORKING,
  input  logic            iCH_WRITE,
  input  logic [CH_W-1:0] iCH_SEL,
  input  logic            iCH_ENA,
  input  logic            iCH_PERIODIC,
  input  logic [63:0]     iCH_COMPARE,
  input  logic [63:0]     iCH_PERIOD,
  output logic [CH_N-1:0] oCH_PENDING,
  output logic [CH_N-1:0] oCH_OVERRUN,
  output logic            oIRQ_VALID,
  output logic [CH_W-1:0] oIRQ_NUM,
  input  logic            iIRQ_ACK
);

  // Handshake: oIRQ_VALID/oIRQ_NUM rise together and hold until iIRQ_ACK is
  // sampled high; that edge retires the request. Ack while not valid is ignored.

  arb_state_t      state;
  logic [CH_W-1:0] rr_ptr;
  logic [CH_N-1:0] clear_vec;
  logic            sel_found;
  logic [CH_W-1:0] sel_idx;
  int              idx;

  always_comb begin
    clear_vec = '0;
    if ((state == ST_ISSUE) && iIRQ_ACK) clear_vec[oIRQ_NUM] = 1'b1;
  end

  // Walk offsets from far to near so the nearest pending channel at or after
  // rr_ptr is the last one written.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = rr_ptr;
    idx       = 0;
    for (int i = CH_N - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % CH_N;
      if (oCH_PENDING[idx]) begin
        sel_found = 1'b1;
        sel_idx   = CH_W'(idx);
      end
    end
  end

  for (genvar g = 0; g < CH_N; g++) begin : g_ch
    logic write_ch;
    assign write_ch = iCH_WRITE && (iCH_SEL == CH_W'(g));

    compare_channel u_ch (
      .clk           (iCLOCK),
      .reset         (iRESET_SYNC),
      .counter       (iCOUNTER),
      .working       (iWORKING),
      .write         (write_ch),
      .cfg_ena       (iCH_ENA),
      .cfg_periodic  (iCH_PERIODIC),
      .cfg_compare   (iCH_COMPARE),
      .cfg_period    (iCH_PERIOD),
      .clear_pending (clear_vec[g]),
      .pending       (oCH_PENDING[g]),
      .overrun       (oCH_OVERRUN[g])
    );
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state      <= ST_IDLE;
      oIRQ_VALID <= 1'b0;
      oIRQ_NUM   <= '0;
      rr_ptr     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel_found) begin
            oIRQ_NUM   <= sel_idx;
            oIRQ_VALID <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (iIRQ_ACK) begin
            oIRQ_VALID <= 1'b0;
            rr_ptr     <= (oIRQ_NUM == CH_W'(CH_N - 1)) ? '0 : oIRQ_NUM + CH_W'(1);
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_compare_irq_scheduler.sv
// Bench for compare_irq_scheduler: directed scenarios plus a randomized run
// checked against a behavioural model of channels and the round-robin grant.
module tb_compare_irq_scheduler;

  localparam int CH_N = 4;
  localparam int CH_W = 2;

  logic            clk = 1'b0;
  logic            rst, working, wr, c_ena, c_per, ack;
  logic [CH_W-1:0] sel;
  logic [63:0]     cnt, c_cmp, c_prd;
  logic [CH_N-1:0] pending, overrun;
  logic            irq_valid;
  logic [CH_W-1:0] irq_num;

  int tests_run = 0;
  int failed    = 0;

  // Behavioural model state
  bit              m_ena [CH_N];
  bit              m_per [CH_N];
  logic [63:0]     m_cmp [CH_N];
  logic [63:0]     m_prd [CH_N];
  logic [CH_N-1:0] m_pend, m_ovr;
  bit              m_valid;
  logic [CH_W-1:0] m_num;
  int              m_rr;

  always #5 clk = ~clk;

  compare_irq_scheduler #(.CH_N(CH_N), .CH_W(CH_W)) dut (
    .iCLOCK       (clk),
    .iRESET_SYNC  (rst),
    .iCOUNTER     (cnt),
    .iWORKING     (working),
    .iCH_WRITE    (wr),
    .iCH_SEL      (sel),
    .iCH_ENA      (c_ena),
    .iCH_PERIODIC (c_per),
    .iCH_COMPARE  (c_cmp),
    .iCH_PERIOD   (c_prd),
    .oCH_PENDING  (pending),
    .oCH_OVERRUN  (overrun),
    .oIRQ_VALID   (irq_valid),
    .oIRQ_NUM     (irq_num),
    .iIRQ_ACK     (ack)
  );

  // Advance the model by one edge using the current inputs, then clock the DUT.
  task automatic tick();
    logic [CH_N-1:0] old_pend;
    bit              old_valid;
    logic [CH_W-1:0] old_num;
    bit              hit, cleared, loaded;
    int              pick;
    old_pend  = m_pend;
    old_valid = m_valid;
    old_num   = m_num;
    if (rst) begin
      for (int ch = 0; ch < CH_N; ch++) begin
        m_ena[ch] = 0; m_per[ch] = 0; m_cmp[ch] = '0; m_prd[ch] = '0;
      end
      m_pend = '0; m_ovr = '0; m_valid = 0; m_num = '0; m_rr = 0;
    end else begin
      for (int ch = 0; ch < CH_N; ch++) begin
        hit     = working && m_ena[ch] && (cnt == m_cmp[ch]);
        cleared = old_valid && ack && (int'(old_num) == ch);
        loaded  = wr && (int'(sel) == ch);
        if (loaded) begin
          m_ena[ch] = c_ena; m_per[ch] = c_per; m_cmp[ch] = c_cmp; m_prd[ch] = c_prd;
          m_ovr[ch] = 1'b0;
          if (cleared) m_pend[ch] = 1'b0;
        end else if (hit) begin
          if (cleared)            m_pend[ch] = 1'b0;
          else if (old_pend[ch])  m_ovr[ch]  = 1'b1;
          else                    m_pend[ch] = 1'b1;
          if (m_per[ch] && m_prd[ch] != 0) m_cmp[ch] = m_cmp[ch] + m_prd[ch];
          else                             m_ena[ch] = 0;
        end else if (cleared) begin
          m_pend[ch] = 1'b0;
        end
      end
      if (!old_valid) begin
        for (int k = 0; k < CH_N; k++) begin
          pick = (m_rr + k) % CH_N;
          if (old_pend[pick] && !m_valid) begin
            m_valid = 1;
            m_num   = CH_W'(pick);
          end
        end
      end else if (ack) begin
        m_valid = 0;
        m_rr    = (int'(old_num) + 1) % CH_N;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr = 1'b0; ack = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic cfg(input int ch, input bit e, input bit p, input logic [63:0] c, input logic [63:0] pr);
    wr = 1'b1; sel = CH_W'(ch); c_ena = e; c_per = p; c_cmp = c; c_prd = pr;
    tick();
    wr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ack = 1'b0; wr = 1'b0; working = 1'b0; cnt = '0;
    tick(); tick();
    rst = 1'b0;
    tests_run++; if (irq_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %0b expected 0", irq_valid); end
    tests_run++; if (irq_num !== 2'd0) begin failed++; $display("FAIL reset_num: got %0d expected 0", irq_num); end
    tests_run++; if (pending !== 4'b0000) begin failed++; $display("FAIL reset_pending: got %b expected 0000", pending); end
    tests_run++; if (overrun !== 4'b0000) begin failed++; $display("FAIL reset_overrun: got %b expected 0000", overrun); end
  endtask

  task automatic test_one_shot();
    do_reset();
    working = 1'b1; cnt = '0;
    cfg(0, 1, 0, 64'h10, 64'h0);
    for (int c = 1; c <= 16; c++) begin cnt = 64'(c); tick(); end
    tests_run++; if (pending !== 4'b0001) begin failed++; $display("FAIL oneshot_pending: got %b expected 0001", pending); end
    tests_run++; if (irq_valid !== 1'b0) begin failed++; $display("FAIL oneshot_early_valid: got %0b expected 0", irq_valid); end
    cnt = 64'h11; tick();
    tests_run++; if (irq_valid !== 1'b1 || irq_num !== 2'd0) begin failed++; $display("FAIL oneshot_grant: got valid=%0b num=%0d expected valid=1 num=0", irq_valid, irq_num); end
    ack = 1'b1; cnt = 64'h12; tick(); ack = 1'b0;
    tests_run++; if (irq_valid !== 1'b0 || pending !== 4'b0000) begin failed++; $display("FAIL oneshot_ack: got valid=%0b pend=%b expected valid=0 pend=0000", irq_valid, pending); end
    cnt = 64'hFFFF_FFFF_FFFF_FFFE; tick();
    cnt = 64'hFFFF_FFFF_FFFF_FFFF; tick();
    for (int c = 0; c <= 20; c++) begin cnt = 64'(c); tick(); end
    tests_run++; if (pending !== 4'b0000 || irq_valid !== 1'b0) begin failed++; $display("FAIL oneshot_no_rematch: got pend=%b valid=%0b expected 0000/0", pending, irq_valid); end
  endtask

  task automatic test_periodic();
    logic [63:0] exp_q[$];
    logic [63:0] exp_v;
    bit          prev;
    do_reset();
    working = 1'b1; cnt = 64'hF0;
    cfg(1, 1, 1, 64'h100, 64'h40);
    exp_q = '{64'h100, 64'h140, 64'h180};
    prev = 0;
    for (int c = 'hF1; c <= 'h1A0; c++) begin
      cnt = 64'(c); tick();
      if (pending[1] && !prev) begin
        tests_run++;
        if (exp_q.size() == 0) begin failed++; $display("FAIL periodic_extra_match: got match at %0h expected none", cnt); end
        else begin
          exp_v = exp_q.pop_front();
          if (cnt !== exp_v) begin failed++; $display("FAIL periodic_match_at: got %0h expected %0h", cnt, exp_v); end
        end
      end
      prev = pending[1];
      ack  = irq_valid;
    end
    ack = 1'b0;
    tests_run++; if (exp_q.size() != 0) begin failed++; $display("FAIL periodic_missing: got %0d unmatched expected 0", exp_q.size()); end
    cfg(2, 1, 1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20);
    cnt = 64'hFFFF_FFFF_FFFF_FFF0; tick();
    tests_run++; if (pending[2] !== 1'b1) begin failed++; $display("FAIL wrap_first: got %0b expected 1", pending[2]); end
    cnt = 64'h5; tick();
    ack = 1'b1; tick(); ack = 1'b0;
    tests_run++; if (pending[2] !== 1'b0) begin failed++; $display("FAIL wrap_ack: got %0b expected 0", pending[2]); end
    cnt = 64'h10; tick();
    tests_run++; if (pending[2] !== 1'b1) begin failed++; $display("FAIL wrap_reload: got %0b expected 1", pending[2]); end
    cnt = 64'h11; tick();
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [CH_W-1:0] grant_q[$];
    logic [CH_W-1:0] exp_g;
    bit              prev_valid;
    do_reset();
    working = 1'b1; cnt = 64'h10;
    cfg(0, 1, 1, 64'h20, 64'h4);
    cfg(2, 1, 0, 64'h20, 64'h0);
    cfg(3, 1, 0, 64'h20, 64'h0);
    grant_q = '{2'd0, 2'd2, 2'd3, 2'd0};
    prev_valid = 0;
    for (int i = 0; i < 12; i++) begin
      cnt = 64'h20 + 64'(i); tick();
      if (irq_valid && !prev_valid) begin
        tests_run++;
        if (grant_q.size() == 0) begin failed++; $display("FAIL rr_extra_grant: got ch %0d expected none", irq_num); end
        else begin
          exp_g = grant_q.pop_front();
          if (irq_num !== exp_g) begin failed++; $display("FAIL rr_order: got ch %0d expected ch %0d", irq_num, exp_g); end
        end
      end
      if (i == 8) begin
        tests_run++;
        if (pending[0] !== 1'b0 || overrun[0] !== 1'b0) begin failed++; $display("FAIL ack_rematch: got pend=%0b ovr=%0b expected 0/0", pending[0], overrun[0]); end
      end
      prev_valid = irq_valid;
      ack = irq_valid;
    end
    ack = 1'b0;
    cnt = 64'h2C;
    cfg(0, 0, 0, 64'h0, 64'h0);
    tests_run++; if (grant_q.size() != 0) begin failed++; $display("FAIL rr_missing: got %0d grants left expected 0", grant_q.size()); end
  endtask

  task automatic test_overrun();
    do_reset();
    working = 1'b1; cnt = 64'h3F;
    cfg(2, 1, 1, 64'h40, 64'h4);
    for (int c = 'h40; c <= 'h49; c++) begin cnt = 64'(c); tick(); end
    tests_run++; if (overrun !== 4'b0100 || pending !== 4'b0100) begin failed++; $display("FAIL overrun_set: got ovr=%b pend=%b expected 0100/0100", overrun, pending); end
    tests_run++; if (irq_valid !== 1'b1 || irq_num !== 2'd2) begin failed++; $display("FAIL overrun_held: got valid=%0b num=%0d expected 1/2", irq_valid, irq_num); end
    cnt = 64'h4A;
    cfg(2, 0, 0, 64'h0, 64'h0);
    tests_run++; if (overrun !== 4'b0000 || pending !== 4'b0100) begin failed++; $display("FAIL overrun_write_clear: got ovr=%b pend=%b expected 0000/0100", overrun, pending); end
    ack = 1'b1; tick(); ack = 1'b0;
    tests_run++; if (pending !== 4'b0000) begin failed++; $display("FAIL overrun_ack: got %b expected 0000", pending); end
  endtask

  task automatic test_write_collision();
    do_reset();
    working = 1'b1; cnt = 64'h4F;
    cfg(1, 1, 0, 64'h50, 64'h0);
    cnt = 64'h50;
    cfg(1, 1, 0, 64'h60, 64'h0);
    tests_run++; if (pending !== 4'b0000) begin failed++; $display("FAIL wr_collision_pend: got %b expected 0000", pending); end
    cnt = 64'h51; tick();
    tests_run++; if (pending !== 4'b0000 || irq_valid !== 1'b0) begin failed++; $display("FAIL wr_collision_after: got pend=%b valid=%0b expected 0000/0", pending, irq_valid); end
    cnt = 64'h60; tick();
    tests_run++; if (pending !== 4'b0010) begin failed++; $display("FAIL wr_collision_new_cmp: got %b expected 0010", pending); end
    cnt = 64'h61; tick();
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    working = 1'b1; cnt = 64'h6F;
    cfg(2, 1, 1, 64'h70, 64'h1);
    cfg(3, 1, 0, 64'h70, 64'h0);
    cnt = 64'h70; tick();
    cnt = 64'h71; tick();
    tests_run++; if (irq_valid !== 1'b1 || irq_num !== 2'd2 || overrun[2] !== 1'b1) begin failed++; $display("FAIL midreset_setup: got valid=%0b num=%0d ovr=%b expected 1/2/x1xx", irq_valid, irq_num, overrun); end
    rst = 1'b1; tick(); rst = 1'b0;
    tests_run++; if (irq_valid !== 1'b0 || irq_num !== 2'd0) begin failed++; $display("FAIL midreset_irq: got valid=%0b num=%0d expected 0/0", irq_valid, irq_num); end
    tests_run++; if (pending !== 4'b0000 || overrun !== 4'b0000) begin failed++; $display("FAIL midreset_flags: got pend=%b ovr=%b expected 0000/0000", pending, overrun); end
    working = 1'b0; cnt = 64'h7F;
    cfg(3, 1, 0, 64'h80, 64'h0);
    cnt = 64'h80; tick(); tick();
    tests_run++; if (pending !== 4'b0000 || irq_valid !== 1'b0) begin failed++; $display("FAIL not_working: got pend=%b valid=%0b expected 0000/0", pending, irq_valid); end
    working = 1'b1; tick();
    tests_run++; if (pending !== 4'b1000) begin failed++; $display("FAIL working_resume: got %b expected 1000", pending); end
    tick();
    tests_run++; if (irq_valid !== 1'b1 || irq_num !== 2'd3) begin failed++; $display("FAIL idle_after_reset: got valid=%0b num=%0d expected 1/3", irq_valid, irq_num); end
  endtask

  task automatic test_random();
    do_reset();
    working = 1'b1; cnt = '0;
    for (int i = 0; i < 3000; i++) begin
      wr      = ($urandom_range(0, 7) == 0);
      sel     = CH_W'($urandom_range(0, CH_N - 1));
      c_ena   = ($urandom_range(0, 3) != 0);
      c_per   = $urandom_range(0, 1) == 1;
      c_cmp   = cnt + 64'($urandom_range(0, 24));
      c_prd   = 64'($urandom_range(0, 6));
      ack     = ($urandom_range(0, 2) == 0);
      working = ($urandom_range(0, 15) != 0);
      rst     = ($urandom_range(0, 299) == 0);
      tick();
      tests_run++; if (pending !== m_pend) begin failed++; $display("FAIL rand_pending @%0d: got %b expected %b", i, pending, m_pend); end
      tests_run++; if (overrun !== m_ovr) begin failed++; $display("FAIL rand_overrun @%0d: got %b expected %b", i, overrun, m_ovr); end
      tests_run++; if (irq_valid !== m_valid) begin failed++; $display("FAIL rand_valid @%0d: got %0b expected %0b", i, irq_valid, m_valid); end
      tests_run++; if (m_valid && irq_num !== m_num) begin failed++; $display("FAIL rand_num @%0d: got %0d expected %0d", i, irq_num, m_num); end
      if ($urandom_range(0, 499) == 0) cnt = 64'hFFFF_FFFF_FFFF_FFF8;
      else                             cnt = cnt + 64'($urandom_range(0, 2));
    end
    rst = 1'b0; wr = 1'b0; ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; working = 1'b0; wr = 1'b0; sel = '0; c_ena = 1'b0; c_per = 1'b0;
    c_cmp = '0; c_prd = '0; cnt = '0; ack = 1'b0;
    test_reset();
    test_one_shot();
    test_periodic();
    test_round_robin();
    test_overrun();
    test_write_collision();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
